word_port_bus_ctrl: RTL and testbench
=====================================

// Module: word_port_bus_ctrl
// PURPOSE
// - Amiga-side cycle generator for 16-bit word ports (chipset regs, Zorro-II style I/O) behind the U111 bus sizer.
// - Captures each local _TS, reports PORTSIZE, drives 68000-style _AS/_UDS/_LDS, waits for port _DTACK (or times out).
// - Returns a one-clock _TACK (normal) or _TEA (error) that the bus sizing state machine consumes.
// - Handles back-to-back sub-cycles: a long word to a word port arrives as two _TS pulses, high word then low word.
// PARAMETERS
// - STROBE_MIN   2    min CLK40 clocks _UDS/_LDS held asserted before _DTACK is honoured
// - TIMEOUT_CLKS 255  CLK40 clocks in WAIT_ACK with no _DTACK before _TEA (8-bit counter; max 255)
// PORTS
// - CLK40     in   1  40MHz local bus clock; all logic on posedge
// - RESETn    in   1  synchronous active-low reset
// - TSn       in   1  local transfer start from U111, one clock low
// - RnW       in   1  1=read, 0=write; sampled with TSn
// - SIZ       in   2  68040 size: 00=long, 01=byte, 10=word, 11=line
// - A_AMIGA   in   2  local address bits [1:0]
// - WORD_CS   in   1  address decode: 1 = cycle targets a word port; stable while TSn low
// - DTACKn    in   1  asynchronous port acknowledge, active low
// - PORTSIZE  out  1  1 = current cycle is to a word port
// - TACKn     out  1  normal termination, one clock low
// - TEAn      out  1  error termination, one clock low
// - TBIn      out  1  burst inhibit, low with TACKn on word-port cycles
// - TCIn      out  1  cache inhibit, low with TACKn on word-port cycles
// - ASn       out  1  port address strobe
// - UDSn      out  1  upper data strobe (D_UU lane)
// - LDSn      out  1  lower data strobe (D_UM lane)
// - PRWn      out  1  port read/write, 1 when idle
// BEHAVIOUR
// - Reset: state IDLE; counters 0; PORTSIZE=0; TACKn, TEAn, TBIn, TCIn, ASn, UDSn, LDSn, PRWn = 1; sync flops = 1.
// - Reset mid-cycle: all strobes negate on the reset edge; no TACK/TEA is emitted for the aborted cycle.
// - DTACKn passes through a 2-flop synchronizer; only the synchronized value (DTACK_S) is used.
// - PORTSIZE = WORD_CS while IDLE (combinational); held at the latched value from capture until the clock after termination.
// - Capture: at any posedge with TSn=0 and WORD_CS=1, latch RnW, SIZ, A_AMIGA[0]. TSn with WORD_CS=0 is ignored entirely.
// - Strobe decode: SIZ 00/10/11 -> UDS and LDS; SIZ 01 with A0=0 -> UDS only; with A0=1 -> LDS only.
// - States:
//   IDLE     : on capture -> ASSERT.
//   ASSERT   : ASn=0, PRWn=latched RnW, selected UDSn/LDSn=0; strobe counter cleared -> WAIT_ACK.
//   WAIT_ACK : strobe and timeout counters increment each clock (timeout saturates).
//              DTACK_S=0 and strobe count >= STROBE_MIN -> TERM_OK.
//              Otherwise timeout count = TIMEOUT_CLKS -> TERM_ERR.
//              If both hold on the same clock, TERM_OK wins.
//   TERM_OK  : TACKn=0, TBIn=0, TCIn=0 for exactly one clock; TEAn=1; strobes negate on the same edge -> RECOVER.
//   TERM_ERR : TEAn=0 for exactly one clock; TACKn=1; strobes negate -> RECOVER.
//   RECOVER  : one clock, strobes high.
//              -> ASSERT if a pending capture exists; -> IDLE once DTACK_S=1 or no capture is pending.
// - Termination latency: TACKn falls the clock after WAIT_ACK qualifies.
//   Min TSn-to-TACKn = 3 + STROBE_MIN clocks with DTACKn already low.
// - Pending capture: a TSn=0 & WORD_CS=1 seen in TERM_OK, TERM_ERR or RECOVER sets PEND and latches attributes.
//   PEND is consumed in RECOVER, so a second sub-cycle issued 1-2 clocks after TACK is never lost.
// - A TSn seen while in ASSERT/WAIT_ACK is a protocol error: it is ignored and does not disturb the cycle.
// - TACKn and TEAn are never low on the same clock.
// STRUCTURE
// - Shared package: state encoding enum; SIZ codes (SIZ_LONG, SIZ_BYTE, SIZ_WORD, SIZ_LINE); termination pair constants {TACKn,TEAn}.
// - One sub-module: sync2 (2-flop synchronizer with a reset value input), reused for DTACKn.
// - Everything else inline: one FSM always block, counters, and the strobe decode.
// TESTING
// - Word read, SIZ=10, A=00, DTACKn tied low
//   -> ASn/UDSn/LDSn low; TACKn low 1 clk at 3+STROBE_MIN clocks after TSn; TBIn=TCIn=0 on that clock.
// - Byte write, SIZ=01, A=01
//   -> only LDSn asserts; PRWn=0 while ASn is low; UDSn stays 1 throughout.
// - Long write split: second TSn 2 clocks after first TACKn
//   -> PEND path taken; two full strobe cycles; two TACK pulses; no dropped cycle.
// - DTACKn never asserts
//   -> TEAn low 1 clk after TIMEOUT_CLKS clocks in WAIT_ACK; TACKn stays 1; strobes released.
// - RESETn low in WAIT_ACK
//   -> all outputs at their reset values next edge; no TACK/TEA; the next TSn starts cleanly.
// - TSn with WORD_CS=0
//   -> PORTSIZE=0, no strobes and no termination from this block.

Source files
------------

// File: rtl/word_port_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// word_port_bus_ctrl_pkg
// Shared definitions for the word-port cycle generator:
//   - FSM state encoding
//   - 68040 SIZ codes
//   - termination pair constants, packed as {TACKn, TEAn}
//   - strobe lane decode helper
// ---------------------------------------------------------------------------
package word_port_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSERT   = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_TERM_OK  = 3'd3,
        ST_TERM_ERR = 3'd4,
        ST_RECOVER  = 3'd5
    } state_t;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    // {TACKn, TEAn}
    localparam logic [1:0] TERM_PAIR_NONE = 2'b11;
    localparam logic [1:0] TERM_PAIR_ACK  = 2'b01;
    localparam logic [1:0] TERM_PAIR_ERR  = 2'b10;

    // Active-high lane enables {upper, lower}. Only a byte access picks a
    // single lane, chosen by A0. A1 never affects a 16-bit port.
    function automatic logic [1:0] strobe_lanes(input logic [1:0] siz,
                                                input logic [1:0] addr);
        logic [1:0] lanes;
        case (siz)
            SIZ_LONG, SIZ_WORD, SIZ_LINE: lanes = 2'b11;
            SIZ_BYTE: begin
                casez (addr)
                    2'b?0:   lanes = 2'b10;
                    2'b?1:   lanes = 2'b01;
                    default: lanes = 2'b11;
                endcase
            end
            default: lanes = 2'b11;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/word_port_bus_ctrl_sync2.sv
// ---------------------------------------------------------------------------
// word_port_bus_ctrl_sync2
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   CLK40   in  clock
//   RESETn  in  synchronous active-low reset
//   rst_val in  value both stages take during reset
//   d       in  asynchronous input
//   q       out synchronized output
// ---------------------------------------------------------------------------
module word_port_bus_ctrl_sync2 (
    input  logic CLK40,
    input  logic RESETn,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; both stages preset to rst_val while in reset
    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            meta_r <= rst_val;
            sync_r <= rst_val;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/word_port_bus_ctrl.sv
// ---------------------------------------------------------------------------
// word_port_bus_ctrl
// Generates 68000-style cycles to 16-bit word ports behind the bus sizer.
// Each local TSn targeting a word port is captured, run as an _AS/_UDS/_LDS
// cycle, and terminated with a one-clock TACKn (port DTACKn) or TEAn
// (timeout). A TSn arriving during termination/recovery is held pending so
// the second half of a split long word is never lost.
// Ports:
//   CLK40, RESETn            clock, synchronous active-low reset
//   TSn, RnW, SIZ, A_AMIGA   local cycle request and attributes
//   WORD_CS                  decode: cycle targets a word port
//   DTACKn                   asynchronous port acknowledge
//   PORTSIZE                 1 while the cycle is to a word port
//   TACKn, TEAn, TBIn, TCIn  local termination
//   ASn, UDSn, LDSn, PRWn    port-side strobes
// All outputs except PORTSIZE in IDLE are registered and reflect the state
// the FSM was in on the previous clock.
// ---------------------------------------------------------------------------
module word_port_bus_ctrl
    import word_port_bus_ctrl_pkg::*;
#(
    parameter int STROBE_MIN   = 2,
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       TSn,
    input  logic       RnW,
    input  logic [1:0] SIZ,
    input  logic [1:0] A_AMIGA,
    input  logic       WORD_CS,
    input  logic       DTACKn,
    output logic       PORTSIZE,
    output logic       TACKn,
    output logic       TEAn,
    output logic       TBIn,
    output logic       TCIn,
    output logic       ASn,
    output logic       UDSn,
    output logic       LDSn,
    output logic       PRWn
);

    localparam logic [7:0] STROBE_MIN_C = 8'(STROBE_MIN);
    localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT_CLKS);

    state_t     state_r;
    logic       pend_r;
    logic       rnw_r;
    logic [1:0] siz_r;
    logic [1:0] addr_r;
    logic       portsize_r;
    logic [7:0] strobe_cnt_r;
    logic [7:0] timeout_cnt_r;
    logic [1:0] term_r;
    logic       tbi_n_r;
    logic       tci_n_r;
    logic       as_n_r;
    logic       uds_n_r;
    logic       lds_n_r;
    logic       prw_n_r;

    logic       dtack_s;
    logic       capture_s;
    logic [1:0] lanes_s;

    word_port_bus_ctrl_sync2 u_dtack_sync (
        .CLK40   (CLK40),
        .RESETn  (RESETn),
        .rst_val (1'b1),
        .d       (DTACKn),
        .q       (dtack_s)
    );

    assign capture_s = ~TSn & WORD_CS;
    assign lanes_s   = strobe_lanes(siz_r, addr_r);

    // Cycle FSM with counters, attribute latches and registered outputs
    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state_r       <= ST_IDLE;
            pend_r        <= 1'b0;
            rnw_r         <= 1'b1;
            siz_r         <= SIZ_LONG;
            addr_r        <= 2'b00;
            portsize_r    <= 1'b0;
            strobe_cnt_r  <= 8'd0;
            timeout_cnt_r <= 8'd0;
            term_r        <= TERM_PAIR_NONE;
            tbi_n_r       <= 1'b1;
            tci_n_r       <= 1'b1;
            as_n_r        <= 1'b1;
            uds_n_r       <= 1'b1;
            lds_n_r       <= 1'b1;
            prw_n_r       <= 1'b1;
        end else begin
            // Outputs idle unless the current state drives them
            term_r  <= TERM_PAIR_NONE;
            tbi_n_r <= 1'b1;
            tci_n_r <= 1'b1;
            as_n_r  <= 1'b1;
            uds_n_r <= 1'b1;
            lds_n_r <= 1'b1;
            prw_n_r <= 1'b1;

            case (state_r)
                ST_IDLE: begin
                    if (capture_s) begin
                        rnw_r      <= RnW;
                        siz_r      <= SIZ;
                        addr_r     <= A_AMIGA;
                        portsize_r <= 1'b1;
                        state_r    <= ST_ASSERT;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                ST_ASSERT: begin
                    as_n_r        <= 1'b0;
                    prw_n_r       <= rnw_r;
                    uds_n_r       <= ~lanes_s[1];
                    lds_n_r       <= ~lanes_s[0];
                    strobe_cnt_r  <= 8'd0;
                    timeout_cnt_r <= 8'd0;
                    state_r       <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    as_n_r  <= 1'b0;
                    prw_n_r <= rnw_r;
                    uds_n_r <= ~lanes_s[1];
                    lds_n_r <= ~lanes_s[0];
                    if (strobe_cnt_r != 8'hFF) begin
                        strobe_cnt_r <= strobe_cnt_r + 8'd1;
                    end
                    if (timeout_cnt_r != 8'hFF) begin
                        timeout_cnt_r <= timeout_cnt_r + 8'd1;
                    end
                    // Acknowledge is checked first so it wins a tie with timeout
                    if (!dtack_s && (strobe_cnt_r >= STROBE_MIN_C)) begin
                        state_r <= ST_TERM_OK;
                    end else if (timeout_cnt_r == TIMEOUT_C) begin
                        state_r <= ST_TERM_ERR;
                    end else begin
                        state_r <= ST_WAIT_ACK;
                    end
                end

                ST_TERM_OK, ST_TERM_ERR: begin
                    if (state_r == ST_TERM_OK) begin
                        term_r  <= TERM_PAIR_ACK;
                        tbi_n_r <= 1'b0;
                        tci_n_r <= 1'b0;
                    end else begin
                        term_r  <= TERM_PAIR_ERR;
                    end
                    if (capture_s) begin
                        pend_r <= 1'b1;
                        rnw_r  <= RnW;
                        siz_r  <= SIZ;
                        addr_r <= A_AMIGA;
                    end
                    state_r <= ST_RECOVER;
                end

                ST_RECOVER: begin
                    if (capture_s) begin
                        rnw_r  <= RnW;
                        siz_r  <= SIZ;
                        addr_r <= A_AMIGA;
                    end
                    // A request seen during termination or right now starts
                    // the next sub-cycle without passing through IDLE
                    if (pend_r || capture_s) begin
                        pend_r     <= 1'b0;
                        portsize_r <= 1'b1;
                        state_r    <= ST_ASSERT;
                    end else begin
                        portsize_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end

                default: begin
                    pend_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // PORTSIZE follows the decode directly while idle so the sizer sees it
    // together with TSn
    assign PORTSIZE = (state_r == ST_IDLE) ? WORD_CS : portsize_r;
    assign TACKn    = term_r[1];
    assign TEAn     = term_r[0];
    assign TBIn     = tbi_n_r;
    assign TCIn     = tci_n_r;
    assign ASn      = as_n_r;
    assign UDSn     = uds_n_r;
    assign LDSn     = lds_n_r;
    assign PRWn     = prw_n_r;

endmodule

// File: tb/tb_word_port_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_word_port_bus_ctrl
// Directed bench for word_port_bus_ctrl (STROBE_MIN=2, TIMEOUT_CLKS=255).
// Edge 0 is the posedge that samples TSn low; outputs are observed 1 time
// unit after each later posedge k. Expected timing for a normal cycle:
// strobes low for k=1..4, TACKn/TBIn/TCIn low at k=5 (3 + STROBE_MIN).
// Observation vector: {ASn,UDSn,LDSn,PRWn,TACKn,TEAn,TBIn,TCIn,PORTSIZE}.
// ---------------------------------------------------------------------------
module tb_word_port_bus_ctrl;

    logic       CLK40 = 1'b0;
    logic       RESETn;
    logic       TSn;
    logic       RnW;
    logic [1:0] SIZ;
    logic [1:0] A_AMIGA;
    logic       WORD_CS;
    logic       DTACKn;
    logic       PORTSIZE, TACKn, TEAn, TBIn, TCIn, ASn, UDSn, LDSn, PRWn;

    int errors = 0;
    int checks = 0;

    logic [8:0] obs_s;
    assign obs_s = {ASn, UDSn, LDSn, PRWn, TACKn, TEAn, TBIn, TCIn, PORTSIZE};

    localparam logic [8:0] RESET_VEC = 9'b1111_1111_0;

    always #12 CLK40 = ~CLK40;

    word_port_bus_ctrl #(
        .STROBE_MIN   (2),
        .TIMEOUT_CLKS (255)
    ) dut (
        .CLK40    (CLK40),
        .RESETn   (RESETn),
        .TSn      (TSn),
        .RnW      (RnW),
        .SIZ      (SIZ),
        .A_AMIGA  (A_AMIGA),
        .WORD_CS  (WORD_CS),
        .DTACKn   (DTACKn),
        .PORTSIZE (PORTSIZE),
        .TACKn    (TACKn),
        .TEAn     (TEAn),
        .TBIn     (TBIn),
        .TCIn     (TCIn),
        .ASn      (ASn),
        .UDSn     (UDSn),
        .LDSn     (LDSn),
        .PRWn     (PRWn)
    );

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    // Present one TSn pulse to a word port; returns just after edge 0
    task automatic start_cycle(input logic rnw, input logic [1:0] siz, input logic [1:0] a);
        TSn = 1'b0; RnW = rnw; SIZ = siz; A_AMIGA = a; WORD_CS = 1'b1;
        tick();
        TSn = 1'b1;
    endtask

    task automatic test_reset();
        RESETn = 1'b0; TSn = 1'b1; RnW = 1'b1; SIZ = 2'b00; A_AMIGA = 2'b00;
        WORD_CS = 1'b0; DTACKn = 1'b0;
        tick(); tick();
        checks++;
        if (obs_s !== RESET_VEC) begin
            errors++;
            $display("FAIL reset: got %b expected %b", obs_s, RESET_VEC);
        end
        RESETn = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_word_read();
        logic act;
        logic [8:0] exp;
        start_cycle(1'b1, 2'b10, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            tick();
            act = (k <= 4);
            exp = {~act, ~act, ~act, 1'b1, k != 5, 1'b1, k != 5, k != 5, 1'b1};
            checks++;
            if (obs_s !== exp) begin
                errors++;
                $display("FAIL word_read k=%0d: got %b expected %b", k, obs_s, exp);
            end
        end
    endtask

    task automatic test_strobe_decode();
        // siz, addr, rnw, upper lane active, lower lane active
        logic [1:0] t_siz [5] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b11};
        logic [1:0] t_a   [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        logic       t_rnw [5] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        logic       t_u   [5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
        logic       t_l   [5] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
        logic act;
        logic [8:0] exp;
        for (int i = 0; i < 5; i++) begin
            start_cycle(t_rnw[i], t_siz[i], t_a[i]);
            for (int k = 1; k <= 7; k++) begin
                tick();
                act = (k <= 4);
                exp = {~act, ~(act & t_u[i]), ~(act & t_l[i]),
                       t_rnw[i] ? 1'b1 : ~act,
                       k != 5, 1'b1, k != 5, k != 5, 1'b1};
                checks++;
                if (obs_s !== exp) begin
                    errors++;
                    $display("FAIL strobe_decode entry=%0d k=%0d: got %b expected %b", i, k, obs_s, exp);
                end
            end
        end
    endtask

    // Long write split into two sub-cycles; second TSn sampled at edge s
    task automatic test_back_to_back();
        int s_tab [3] = '{5, 6, 7};
        int s, start;
        logic act, tk;
        logic [8:0] exp;
        for (int i = 0; i < 3; i++) begin
            s = s_tab[i];
            start = (s < 6) ? 6 : s;
            start_cycle(1'b0, 2'b10, 2'b00);
            for (int k = 1; k <= start + 8; k++) begin
                tick();
                act = (k <= 4) || (k >= start + 1 && k <= start + 4);
                tk  = (k == 5) || (k == start + 5);
                exp = {~act, ~act, ~act, ~act, ~tk, 1'b1, ~tk, ~tk, 1'b1};
                checks++;
                if (obs_s !== exp) begin
                    errors++;
                    $display("FAIL back_to_back s=%0d k=%0d: got %b expected %b", s, k, obs_s, exp);
                end
                TSn = (k == s - 1) ? 1'b0 : 1'b1;
            end
        end
    endtask

    // TSn during WAIT_ACK must neither disturb nor start another cycle
    task automatic test_tsn_ignored();
        logic act;
        logic [8:0] exp;
        start_cycle(1'b1, 2'b10, 2'b00);
        for (int k = 1; k <= 12; k++) begin
            tick();
            act = (k <= 4);
            exp = {~act, ~act, ~act, 1'b1, k != 5, 1'b1, k != 5, k != 5, 1'b1};
            checks++;
            if (obs_s !== exp) begin
                errors++;
                $display("FAIL tsn_ignored k=%0d: got %b expected %b", k, obs_s, exp);
            end
            TSn = (k == 1) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_timeout();
        logic act;
        logic [8:0] exp;
        DTACKn = 1'b1;
        tick(); tick(); tick();
        start_cycle(1'b0, 2'b10, 2'b00);
        for (int k = 1; k <= 262; k++) begin
            tick();
            act = (k <= 257);
            exp = {~act, ~act, ~act, ~act, 1'b1, k != 258, 1'b1, 1'b1, 1'b1};
            checks++;
            if (obs_s !== exp) begin
                errors++;
                $display("FAIL timeout k=%0d: got %b expected %b", k, obs_s, exp);
            end
        end
        DTACKn = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp;
        start_cycle(1'b1, 2'b10, 2'b00);
        tick(); tick();
        RESETn = 1'b0; WORD_CS = 1'b0;
        tick();
        checks++;
        if (obs_s !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", obs_s, RESET_VEC);
        end
        RESETn = 1'b1;
        for (int k = 4; k <= 12; k++) begin
            tick();
            checks++;
            if (obs_s !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_mid_quiet k=%0d: got %b expected %b", k, obs_s, RESET_VEC);
            end
        end
        start_cycle(1'b1, 2'b10, 2'b00);
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = {k > 4, k > 4, k > 4, 1'b1, k != 5, 1'b1, k != 5, k != 5, 1'b1};
            checks++;
            if (obs_s !== exp) begin
                errors++;
                $display("FAIL reset_restart k=%0d: got %b expected %b", k, obs_s, exp);
            end
        end
    endtask

    task automatic test_no_word_cs();
        TSn = 1'b0; WORD_CS = 1'b0; RnW = 1'b0; SIZ = 2'b10; A_AMIGA = 2'b00;
        tick();
        TSn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (obs_s !== RESET_VEC) begin
                errors++;
                $display("FAIL no_word_cs k=%0d: got %b expected %b", k, obs_s, RESET_VEC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_strobe_decode();
        test_back_to_back();
        test_tsn_ignored();
        test_timeout();
        test_reset_mid();
        test_no_word_cs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
